// File: rtl/vld_data_fifo.sv
// First-word-fall-through valid/ready buffer stage with flush, occupancy,
// almost-full and high-water-mark reporting. Storage is a circular array.
module vld_data_fifo #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = 3,
  localparam int CW          = $clog2(DEPTH + 1),
  localparam int PW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic [CW-1:0]    hwm
);

  // Handshake: a word moves when valid and ready are both high at a rising
  // edge. in_rdy and out_vld depend only on registered state (plus rst/flush).
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_THRESH);
  localparam logic [CW-1:0] ONE_CNT   = CW'(1);
  localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
  localparam logic [PW-1:0] ONE_PTR   = PW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    r_hwm;

  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_hwm_nxt;
  logic [PW-1:0]    w_rd_ptr_inc;
  logic [PW-1:0]    w_wr_ptr_inc;

  assign in_rdy      = !rst && !flush && (r_count != FULL_CNT);
  assign out_vld     = (r_count != '0);
  assign almost_full = (r_count >= AFULL_CNT);
  assign out_data    = out_vld ? r_mem[r_rd_ptr] : '0;
  assign count       = r_count;
  assign hwm         = r_hwm;

  assign w_push = in_vld && in_rdy;
  assign w_pop  = out_vld && out_rdy;

  // Explicit wrap keeps non-power-of-two depths correct.
  assign w_rd_ptr_inc = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + ONE_PTR;
  assign w_wr_ptr_inc = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + ONE_PTR;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + ONE_CNT;
      2'b01:   w_count_nxt = r_count - ONE_CNT;
      default: w_count_nxt = r_count;
    endcase
  end

  assign w_hwm_nxt = (w_count_nxt > r_hwm) ? w_count_nxt : r_hwm;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_hwm    <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_hwm    <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      r_count <= w_count_nxt;
      r_hwm   <= w_hwm_nxt;
    end
  end

  // Storage is intentionally not reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

endmodule

// File: tb/tb_vld_data_fifo.sv
// Self-checking bench for vld_data_fifo: directed scenarios plus random
// traffic, checked by a queue-based reference model and scoreboard.
module tb_vld_data_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AFT   = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             flush = 1'b0;
  logic             in_vld = 1'b0;
  logic             in_rdy;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_vld;
  logic             out_rdy = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    count;
  logic             almost_full;
  logic [CW-1:0]    hwm;

  vld_data_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .count(count), .almost_full(almost_full), .hwm(hwm)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [WIDTH-1:0] exp_q[$];
  int               model_hwm = 0;
  int               n_total = 0;
  int               n_bad = 0;
  bit               skip_stab = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic vld, input logic [WIDTH-1:0] data,
                       input logic ordy, input logic fl);
    @(negedge clk);
    in_vld  = vld;
    in_data = data;
    out_rdy = ordy;
    flush   = fl;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    flush   = 1'b0;
    while (n < budget) begin
      @(negedge clk);
      if (!out_vld) break;
      n++;
    end
    check("drain_timeout", (n < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  // ---------------- monitor (pops and state checks, before ingress) ----------------
  bit               prev_hold = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  initial begin
    logic [WIDTH-1:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst && ($isunknown(in_vld) || $isunknown(out_rdy)))
        check("x_on_handshake", 32'd1, 32'd0);
      if (skip_stab) begin
        prev_hold = 1'b0;
        skip_stab = 1'b0;
      end
      if (prev_hold && !rst) begin
        check("stab_vld", 32'(out_vld), 32'd1);
        check("stab_data", 32'(out_data), 32'(prev_data));
      end
      check("count", 32'(count), 32'(exp_q.size()));
      check("out_vld", 32'(out_vld), (exp_q.size() != 0) ? 32'd1 : 32'd0);
      check("in_rdy", 32'(in_rdy), (!rst && !flush && exp_q.size() != DEPTH) ? 32'd1 : 32'd0);
      check("almost_full", 32'(almost_full), (exp_q.size() >= AFT) ? 32'd1 : 32'd0);
      check("hwm", 32'(hwm), 32'(model_hwm));
      if (!out_vld) check("data_zero_idle", 32'(out_data), 32'd0);
      if (!rst && !flush && out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("pop_on_empty_model", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e));
        end
      end
      prev_hold = out_vld && !out_rdy && !flush && !rst;
      prev_data = out_data;
    end
  end

  // ---------------- ingress model (pushes, flush, reset, hwm) ----------------
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst || flush) begin
        exp_q.delete();
        model_hwm = 0;
      end else begin
        if (in_vld && in_rdy) exp_q.push_back(in_data);
        if (exp_q.size() > model_hwm) model_hwm = exp_q.size();
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // reset with an offered word that must not be stored
    rst = 1'b1; in_vld = 1'b1; in_data = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_in_rdy", 32'(in_rdy), 32'd0);
      check("rst_out_vld", 32'(out_vld), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_hwm", 32'(hwm), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("post_rst_empty", 32'(out_vld), 32'd0);

    // fill to full with downstream stalled; fifth word held off
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b1, 8'h33, 1'b0, 1'b0);
    check("af_at_2", 32'(almost_full), 32'd0);
    drive(1'b1, 8'h44, 1'b0, 1'b0);
    check("af_at_3", 32'(almost_full), 32'd1);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h55, 1'b0, 1'b0);
    check("full_count", 32'(count), 32'd4);
    check("full_in_rdy", 32'(in_rdy), 32'd0);
    check("full_hwm", 32'(hwm), 32'd4);
    @(negedge clk); in_vld = 1'b0;
    drain(20);
    check("drained_count", 32'(count), 32'd0);

    // backpressure stability
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("bp_vld", 32'(out_vld), 32'd1);
      check("bp_data", 32'(out_data), 32'h3C);
      drive(1'b0, 8'h00, 1'b0, 1'b0);
    end
    drain(20);

    // streaming with pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      if (i >= 2) check("stream_count", 32'(count), 32'd1);
    end
    drain(20);

    // flush colliding with push and pop
    drive(1'b1, 8'hA1, 1'b0, 1'b0);
    drive(1'b1, 8'hA2, 1'b0, 1'b0);
    drive(1'b1, 8'h99, 1'b1, 1'b1);
    check("pre_flush_count", 32'(count), 32'd2);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("flush_count", 32'(count), 32'd0);
    check("flush_hwm", 32'(hwm), 32'd0);
    check("flush_out_vld", 32'(out_vld), 32'd0);
    drive(1'b1, 8'hAB, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("after_flush_head", 32'(out_data), 32'hAB);
    drain(20);

    // asynchronous reset between edges with three entries stored
    drive(1'b1, 8'hC1, 1'b0, 1'b0);
    drive(1'b1, 8'hC2, 1'b0, 1'b0);
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("pre_arst_count", 32'(count), 32'd3);
    #1;
    rst = 1'b1;
    skip_stab = 1'b1;
    #0.5;
    check("arst_out_vld", 32'(out_vld), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_hwm", 32'(hwm), 32'd0);
    exp_q.delete();
    model_hwm = 0;
    #0.5;
    rst = 1'b0;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("arst_first_out", 32'(out_data), 32'h77);
    drain(20);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) != 0), 8'($urandom),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 40) == 0));
    end
    drain(40);
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    check("final_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // absolute time guard
  initial begin
    #200000;
    n_bad++;
    $display("FAIL timeout: simulation did not finish, bad=%0d", n_bad);
    $fatal(1, "timeout");
  end

endmodule
